// File: rtl/ram_pkg.sv
// Shared sizing constants and word type for the 4K x 32 single-port RAM.
package ram_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 32'(1) << ADDR_W;

  typedef logic [DATA_W-1:0] word_t;

endpackage : ram_pkg

// File: rtl/ram_array.sv
// Storage array for ram_4kx32: synchronous write, read path into the
// top-level output register. Holds no reset; contents survive rst.
module ram_array
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_W = ram_pkg::ADDR_W,
  parameter int unsigned WIDTH  = ram_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [WIDTH-1:0]  wdata_i,
  output logic [WIDTH-1:0]  rdata_c
);

  localparam int unsigned ARR_DEPTH = 32'(1) << ADDR_W;

  logic [WIDTH-1:0] mem_q [ARR_DEPTH];

  // Commit the write on the rising edge; address is fully decoded.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  // Read word at the current address; captured by the top on the next edge.
  assign rdata_c = mem_q[addr_i];

endmodule : ram_array

// File: rtl/ram_4kx32.sv
// Single-port 4K x 32 RAM with registered, write-first read data.
// Optional even-parity storage and check when RAM_PARITY_EN is defined.
module ram_4kx32
  import ram_pkg::*;
#(
  parameter int unsigned ADDR_W = ram_pkg::ADDR_W,
  parameter int unsigned DATA_W = ram_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r_wn,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
`ifdef RAM_PARITY_EN
  output logic              parity_err,
`endif
  output logic [DATA_W-1:0] data_out
);

`ifdef RAM_PARITY_EN
  localparam int unsigned STORE_W = DATA_W + 1;
`else
  localparam int unsigned STORE_W = DATA_W;
`endif

  logic               we_c;
  logic [STORE_W-1:0] wword_c;
  logic [STORE_W-1:0] rword_c;
  logic [DATA_W-1:0]  data_d;
  logic [DATA_W-1:0]  data_q;

  // A write only happens outside reset, so an asserted rst aborts it.
  assign we_c = ~rst & ~r_wn;

`ifdef RAM_PARITY_EN
  // Stored parity bit makes the full stored word even.
  assign wword_c = {^data_in, data_in};
`else
  assign wword_c = data_in;
`endif

  ram_array #(
    .ADDR_W (ADDR_W),
    .WIDTH  (STORE_W)
  ) u_array (
    .clk     (clk),
    .we_i    (we_c),
    .addr_i  (address),
    .wdata_i (wword_c),
    .rdata_c (rword_c)
  );

  // Write-first: a write cycle forwards data_in, a read returns the array word.
  always_comb begin
    data_d = data_q;
    if (r_wn) begin
      data_d = rword_c[DATA_W-1:0];
    end else begin
      data_d = data_in;
    end
  end

  // Output data register, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_out = data_q;

`ifdef RAM_PARITY_EN
  logic parity_err_d;
  logic parity_err_q;

  // Odd parity over the stored word flags corruption; writes never flag.
  always_comb begin
    parity_err_d = 1'b0;
    if (r_wn) begin
      parity_err_d = ^rword_c;
    end
  end

  // Parity error flag register, cleared asynchronously by rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err = parity_err_q;
`endif

endmodule : ram_4kx32

// File: tb/tb_ram_4kx32.sv
// Directed self-checking bench for ram_4kx32.
// Define RAM_PARITY_EN to also exercise the parity path.
module tb_ram_4kx32;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4096;

  logic              clk;
  logic              rst;
  logic              r_wn;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
`ifdef RAM_PARITY_EN
  logic              parity_err;
`endif

  int n_checks;
  int n_fails;

  ram_4kx32 #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .r_wn       (r_wn),
    .address    (address),
    .data_in    (data_in),
`ifdef RAM_PARITY_EN
    .parity_err (parity_err),
`endif
    .data_out   (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive a write at the falling edge, let the rising edge take it.
  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    @(negedge clk);
    r_wn    = 1'b0;
    address = a;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  // Drive a read; data_out is valid 1 ns after the capturing edge.
  task automatic do_read(input logic [ADDR_W-1:0] a);
    @(negedge clk);
    r_wn    = 1'b1;
    address = a;
    data_in = 32'h0BAD_0BAD;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst      = 1'b1;
    r_wn     = 1'b1;
    address  = '0;
    data_in  = '0;

    // Reset state
    #3;
    check("reset_data_out", data_out, 32'h0);
`ifdef RAM_PARITY_EN
    check("reset_parity_err", 32'(parity_err), 32'h0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Sequential fill then full readback
    for (int n = 0; n < int'(DEPTH); n++) begin
      do_write(ADDR_W'(n), DATA_W'(n));
    end
    for (int n = 0; n < int'(DEPTH); n++) begin
      do_read(ADDR_W'(n));
      check("fill_read", data_out, DATA_W'(n));
    end

    // Write-first and read-after-write
    do_write(12'hABC, 32'hDEAD_BEEF);
    check("write_first", data_out, 32'hDEAD_BEEF);
    do_read(12'hABC);
    check("raw_read", data_out, 32'hDEAD_BEEF);

    // Reset retention: rst pulsed mid-cycle after the write edge
    do_write(12'h005, 32'h1234_5678);
    check("retain_wr_echo", data_out, 32'h1234_5678);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_clear", data_out, 32'h0);
    @(negedge clk);
    r_wn    = 1'b1;
    address = 12'h005;
    rst     = 1'b0;
    @(posedge clk);
    #1;
    check("first_read_after_reset", data_out, 32'h1234_5678);

    // Aborted write: rst held across a write edge
    do_write(12'h010, 32'h0000_0001);
    @(negedge clk);
    rst     = 1'b1;
    r_wn    = 1'b0;
    address = 12'h010;
    data_in = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    check("reset_holds_zero", data_out, 32'h0);
    @(negedge clk);
    rst     = 1'b0;
    r_wn    = 1'b1;
    @(posedge clk);
    #1;
    check("aborted_write", data_out, 32'h0000_0001);

    // Boundary addresses, no aliasing
    do_write(12'h000, 32'hA5A5_A5A5);
    do_write(12'hFFF, 32'h5A5A_5A5A);
    do_read(12'h000);
    check("boundary_low", data_out, 32'hA5A5_A5A5);
    do_read(12'hFFF);
    check("boundary_high", data_out, 32'h5A5A_5A5A);
    do_read(12'h800);
    check("mid_untouched", data_out, 32'h0000_0800);

    // Consecutive back-to-back writes then reads
    do_write(12'h100, 32'h1111_1111);
    do_write(12'h101, 32'h2222_2222);
    do_write(12'h102, 32'h3333_3333);
    do_read(12'h100);
    check("b2b_0", data_out, 32'h1111_1111);
    do_read(12'h101);
    check("b2b_1", data_out, 32'h2222_2222);
    do_read(12'h102);
    check("b2b_2", data_out, 32'h3333_3333);

`ifdef RAM_PARITY_EN
    // Parity: clean write, corrupted stored parity bit, clean read
    do_write(12'h020, 32'h0000_0007);
    check("parity_after_write", 32'(parity_err), 32'h0);
    @(negedge clk);
    dut.u_array.mem_q[12'h020][DATA_W] = ~dut.u_array.mem_q[12'h020][DATA_W];
    do_read(12'h020);
    check("parity_err_flag", 32'(parity_err), 32'h1);
    check("parity_err_data", data_out, 32'h0000_0007);
    do_read(12'h021);
    check("parity_clean_read", 32'(parity_err), 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_ram_4kx32
